// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the pipelined RV32I control path: opcodes, ALU/result/
// immediate/forwarding selects and branch funct3 values.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7[5] means sub only for R-type; for shifts it always means arithmetic.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7_5,
                                         input logic is_rtype);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_rtype && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard logic: operand forwarding selects, load-use stall and
// the stall/flush controls for the F, D and E stages.
module hazard_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  input  logic [REG_AW-1:0] rs1_e_i,
  input  logic [REG_AW-1:0] rs2_e_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic [1:0]        result_src_e_i,
  input  logic              pc_src_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  output logic [1:0]        forward_a_e_o,
  output logic [1:0]        forward_b_e_o,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_d_o,
  output logic              flush_e_o
);

  logic lw_stall;

  // x0 is never a forwarding source; the younger M result wins over W.
  always_comb begin
    forward_a_e_o = FWD_RF;
    forward_b_e_o = FWD_RF;
    if (rs1_e_i != '0 && reg_write_m_i && rs1_e_i == rd_m_i) begin
      forward_a_e_o = FWD_M;
    end else if (rs1_e_i != '0 && reg_write_w_i && rs1_e_i == rd_w_i) begin
      forward_a_e_o = FWD_W;
    end
    if (rs2_e_i != '0 && reg_write_m_i && rs2_e_i == rd_m_i) begin
      forward_b_e_o = FWD_M;
    end else if (rs2_e_i != '0 && reg_write_w_i && rs2_e_i == rd_w_i) begin
      forward_b_e_o = FWD_W;
    end
  end

  assign lw_stall = (result_src_e_i == RES_MEM) && (rd_e_i != '0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  // A redirect discards the dependent instruction anyway, so it wins over the stall.
  assign stall_f_o = lw_stall & ~pc_src_e_i;
  assign stall_d_o = lw_stall & ~pc_src_e_i;
  assign flush_d_o = pc_src_e_i;
  assign flush_e_o = lw_stall | pc_src_e_i;

endmodule

// File: rtl/pipe_control_path.sv
// Five-stage RV32I control path: D-stage decode, control pipeline registers
// D->E->M->W, E-stage branch resolution and hazard control.
module pipe_control_path
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter bit FULL_BRANCH = 1'b1,
  parameter int REG_AW      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_d,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [2:0]            imm_src_d,
  output logic [ALU_CTRL_W-1:0] alu_cntrl_e,
  output logic                  alu_src_e,
  output logic                  jalr_e,
  output logic                  pc_src_e,
  output logic                  mem_write_m,
  output logic [1:0]            result_src_w,
  output logic                  reg_write_w,
  output logic [REG_AW-1:0]     rd_w,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  illegal_e
);

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [2:0]            funct3;
    logic [ALU_CTRL_W-1:0] alu_cntrl;
    logic                  alu_src;
    logic                  jalr;
    logic                  illegal;
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic [REG_AW-1:0]     rd;
  } de_ctrl_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic [REG_AW-1:0] rd;
  } em_ctrl_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
  } mw_ctrl_t;

  de_ctrl_t          de_d, de_q;
  em_ctrl_t          em_q;
  mw_ctrl_t          mw_q;
  imm_src_t          imm_sel_d;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic              taken_e;
  logic              unused_instr_bits;

  assign rs1_d = REG_AW'(instr_d[19:15]);
  assign rs2_d = REG_AW'(instr_d[24:20]);
  assign rd_d  = REG_AW'(instr_d[11:7]);
  assign unused_instr_bits = ^{instr_d[31], instr_d[29:25]};

  always_comb begin
    de_d           = '0;
    imm_sel_d      = IMM_I;
    de_d.funct3    = instr_d[14:12];
    de_d.rs1       = rs1_d;
    de_d.rs2       = rs2_d;
    de_d.rd        = rd_d;
    de_d.alu_cntrl = ALU_CTRL_W'(ALU_ADD);
    case (instr_d[6:0])
      OP_LOAD: begin
        de_d.reg_write  = 1'b1;
        de_d.result_src = RES_MEM;
        de_d.alu_src    = 1'b1;
      end
      OP_STORE: begin
        de_d.mem_write = 1'b1;
        de_d.alu_src   = 1'b1;
        imm_sel_d      = IMM_S;
      end
      OP_RTYPE: begin
        de_d.reg_write = 1'b1;
        de_d.alu_cntrl = ALU_CTRL_W'(alu_decode(instr_d[14:12], instr_d[30], 1'b1));
      end
      OP_ITYPE: begin
        de_d.reg_write = 1'b1;
        de_d.alu_src   = 1'b1;
        de_d.alu_cntrl = ALU_CTRL_W'(alu_decode(instr_d[14:12], instr_d[30], 1'b0));
      end
      OP_BRANCH: begin
        de_d.branch    = 1'b1;
        de_d.alu_cntrl = ALU_CTRL_W'(ALU_SUB);
        imm_sel_d      = IMM_B;
      end
      OP_JAL: begin
        de_d.reg_write  = 1'b1;
        de_d.result_src = RES_PC4;
        de_d.jump       = 1'b1;
        imm_sel_d       = IMM_J;
      end
      OP_JALR: begin
        de_d.reg_write  = 1'b1;
        de_d.result_src = RES_PC4;
        de_d.jump       = 1'b1;
        de_d.jalr       = 1'b1;
        de_d.alu_src    = 1'b1;
      end
      OP_LUI: begin
        de_d.reg_write  = 1'b1;
        de_d.result_src = RES_IMM;
        de_d.alu_src    = 1'b1;
        imm_sel_d       = IMM_U;
      end
      OP_AUIPC: begin
        de_d.reg_write = 1'b1;
        de_d.alu_src   = 1'b1;
        imm_sel_d      = IMM_U;
      end
      default: de_d.illegal = 1'b1;
    endcase
  end

  assign imm_src_d = imm_sel_d;

  // A flushed E stage holds an all-zero bubble: no writes, no branch, no jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= '0;
    end else if (flush_e) begin
      de_q <= '0;
    end else begin
      de_q <= de_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_q <= '0;
      mw_q <= '0;
    end else begin
      em_q.reg_write  <= de_q.reg_write;
      em_q.result_src <= de_q.result_src;
      em_q.mem_write  <= de_q.mem_write;
      em_q.rd         <= de_q.rd;
      mw_q.reg_write  <= em_q.reg_write;
      mw_q.result_src <= em_q.result_src;
      mw_q.rd         <= em_q.rd;
    end
  end

  always_comb begin
    taken_e = 1'b0;
    case (de_q.funct3)
      F3_BEQ:  taken_e = zero_e;
      F3_BNE:  taken_e = ~zero_e;
      F3_BLT:  taken_e = FULL_BRANCH & lt_e;
      F3_BGE:  taken_e = FULL_BRANCH & ~lt_e;
      F3_BLTU: taken_e = FULL_BRANCH & ltu_e;
      F3_BGEU: taken_e = FULL_BRANCH & ~ltu_e;
      default: taken_e = 1'b0;
    endcase
  end

  assign pc_src_e     = de_q.jump | (de_q.branch & taken_e);
  assign alu_cntrl_e  = de_q.alu_cntrl;
  assign alu_src_e    = de_q.alu_src;
  assign jalr_e       = de_q.jalr;
  assign illegal_e    = de_q.illegal;
  assign mem_write_m  = em_q.mem_write;
  assign result_src_w = mw_q.result_src;
  assign reg_write_w  = mw_q.reg_write;
  assign rd_w         = mw_q.rd;

  hazard_unit #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .rs1_d_i       (rs1_d),
    .rs2_d_i       (rs2_d),
    .rs1_e_i       (de_q.rs1),
    .rs2_e_i       (de_q.rs2),
    .rd_e_i        (de_q.rd),
    .result_src_e_i(de_q.result_src),
    .pc_src_e_i    (pc_src_e),
    .rd_m_i        (em_q.rd),
    .reg_write_m_i (em_q.reg_write),
    .rd_w_i        (mw_q.rd),
    .reg_write_w_i (mw_q.reg_write),
    .forward_a_e_o (forward_a_e),
    .forward_b_e_o (forward_b_e),
    .stall_f_o     (stall_f),
    .stall_d_o     (stall_d),
    .flush_d_o     (flush_d),
    .flush_e_o     (flush_e)
  );

endmodule

// File: tb/tb_pipe_control_path.sv
// Bench for pipe_control_path: directed hazard scenarios then random instruction
// streams, checked against an instruction-record pipeline model.
module tb_pipe_control_path;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_d;
  logic        zero_e, lt_e, ltu_e;
  logic [2:0]  imm_src_d;
  logic [3:0]  alu_cntrl_e;
  logic        alu_src_e, jalr_e, pc_src_e, mem_write_m;
  logic [1:0]  result_src_w;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, flush_d, flush_e, illegal_e;

  logic        nb_pc_src;
  logic [2:0]  nb_unused_imm;
  logic [3:0]  nb_unused_alu;
  logic        nb_unused_src, nb_unused_jalr, nb_unused_mw, nb_unused_rw;
  logic [1:0]  nb_unused_rs, nb_unused_fa, nb_unused_fb;
  logic [4:0]  nb_unused_rd;
  logic        nb_unused_sf, nb_unused_sd, nb_unused_fd, nb_unused_fe, nb_unused_ill;

  int errors = 0;
  int checks = 0;

  pipe_control_path #(.ALU_CTRL_W(4), .FULL_BRANCH(1'b1), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .zero_e(zero_e), .lt_e(lt_e),
    .ltu_e(ltu_e), .imm_src_d(imm_src_d), .alu_cntrl_e(alu_cntrl_e),
    .alu_src_e(alu_src_e), .jalr_e(jalr_e), .pc_src_e(pc_src_e),
    .mem_write_m(mem_write_m), .result_src_w(result_src_w), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .illegal_e(illegal_e)
  );

  pipe_control_path #(.ALU_CTRL_W(4), .FULL_BRANCH(1'b0), .REG_AW(5)) dut_beq (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .zero_e(zero_e), .lt_e(lt_e),
    .ltu_e(ltu_e), .imm_src_d(nb_unused_imm), .alu_cntrl_e(nb_unused_alu),
    .alu_src_e(nb_unused_src), .jalr_e(nb_unused_jalr), .pc_src_e(nb_pc_src),
    .mem_write_m(nb_unused_mw), .result_src_w(nb_unused_rs), .reg_write_w(nb_unused_rw),
    .rd_w(nb_unused_rd), .forward_a_e(nb_unused_fa), .forward_b_e(nb_unused_fb),
    .stall_f(nb_unused_sf), .stall_d(nb_unused_sd), .flush_d(nb_unused_fd),
    .flush_e(nb_unused_fe), .illegal_e(nb_unused_ill)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // One record per instruction; it is decoded once and slides E -> M -> W.
  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       j;
    logic       b;
    logic [2:0] f3;
    logic [3:0] alu;
    logic       src;
    logic       jalr;
    logic       ill;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] rd;
    logic [2:0] imm;
  } rec_t;

  rec_t e_s, m_s, w_s;
  int   f3_alu[8] = '{0, 7, 5, 6, 4, 8, 3, 2};

  function automatic rec_t ref_decode(input logic [31:0] ins);
    rec_t r;
    int   a;
    r = '0;
    r.f3 = ins[14:12];
    r.r1 = ins[19:15];
    r.r2 = ins[24:20];
    r.rd = ins[11:7];
    a = f3_alu[ins[14:12]];
    if (ins[14:12] == 3'd5 && ins[30]) a = 9;
    case (ins[6:0])
      7'b0000011: begin r.rw = 1; r.rs = 2'd1; r.src = 1; end
      7'b0100011: begin r.mw = 1; r.src = 1; r.imm = 3'd1; end
      7'b0110011: begin
        r.rw = 1;
        if (ins[14:12] == 3'd0 && ins[30]) a = 1;
        r.alu = 4'(a);
      end
      7'b0010011: begin r.rw = 1; r.src = 1; r.alu = 4'(a); end
      7'b1100011: begin r.b = 1; r.alu = 4'd1; r.imm = 3'd2; end
      7'b1101111: begin r.rw = 1; r.rs = 2'd2; r.j = 1; r.imm = 3'd3; end
      7'b1100111: begin r.rw = 1; r.rs = 2'd2; r.j = 1; r.jalr = 1; r.src = 1; end
      7'b0110111: begin r.rw = 1; r.rs = 2'd3; r.src = 1; r.imm = 3'd4; end
      7'b0010111: begin r.rw = 1; r.src = 1; r.imm = 3'd4; end
      default:    r.ill = 1;
    endcase
    return r;
  endfunction

  function automatic logic ref_pc(input bit full);
    logic t;
    case (e_s.f3)
      3'd0: t = zero_e;
      3'd1: t = !zero_e;
      3'd4: t = full && lt_e;
      3'd5: t = full && !lt_e;
      3'd6: t = full && ltu_e;
      3'd7: t = full && !ltu_e;
      default: t = 1'b0;
    endcase
    return e_s.j || (e_s.b && t);
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs != 0 && m_s.rw && m_s.rd == rs) return 2'b10;
    if (rs != 0 && w_s.rw && w_s.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_lw_stall();
    rec_t d;
    d = ref_decode(instr_d);
    return (e_s.rs == 2'd1) && (e_s.rd != 0) && (e_s.rd == d.r1 || e_s.rd == d.r2);
  endfunction

  task automatic model_clock();
    logic fe;
    fe = ref_lw_stall() || ref_pc(1'b1);
    if (!rst_n) begin
      e_s = '0; m_s = '0; w_s = '0;
    end else begin
      w_s = m_s;
      m_s = e_s;
      e_s = fe ? '0 : ref_decode(instr_d);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    rec_t d;
    logic pc, lws;
    d   = ref_decode(instr_d);
    pc  = ref_pc(1'b1);
    lws = ref_lw_stall();
    chk({tag, ".imm_src_d"},    32'(imm_src_d),    32'(d.imm));
    chk({tag, ".alu_cntrl_e"},  32'(alu_cntrl_e),  32'(e_s.alu));
    chk({tag, ".alu_src_e"},    32'(alu_src_e),    32'(e_s.src));
    chk({tag, ".jalr_e"},       32'(jalr_e),       32'(e_s.jalr));
    chk({tag, ".pc_src_e"},     32'(pc_src_e),     32'(pc));
    chk({tag, ".mem_write_m"},  32'(mem_write_m),  32'(m_s.mw));
    chk({tag, ".result_src_w"}, 32'(result_src_w), 32'(w_s.rs));
    chk({tag, ".reg_write_w"},  32'(reg_write_w),  32'(w_s.rw));
    chk({tag, ".rd_w"},         32'(rd_w),         32'(w_s.rd));
    chk({tag, ".forward_a_e"},  32'(forward_a_e),  32'(ref_fwd(e_s.r1)));
    chk({tag, ".forward_b_e"},  32'(forward_b_e),  32'(ref_fwd(e_s.r2)));
    chk({tag, ".stall_f"},      32'(stall_f),      32'(lws && !pc));
    chk({tag, ".stall_d"},      32'(stall_d),      32'(lws && !pc));
    chk({tag, ".flush_d"},      32'(flush_d),      32'(pc));
    chk({tag, ".flush_e"},      32'(flush_e),      32'(lws || pc));
    chk({tag, ".illegal_e"},    32'(illegal_e),    32'(e_s.ill));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] ins, input logic z, input logic lt,
                       input logic ltu, input string tag);
    instr_d = ins;
    zero_e  = z;
    lt_e    = lt;
    ltu_e   = ltu;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops[10];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'h7F};
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[6:0]   = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] cur;
    logic        hold, redir;

    rst_n = 1'b0;
    instr_d = NOP; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
    e_s = '0; m_s = '0; w_s = '0;
    @(negedge clk);
    check_all("reset");
    chk("reset.rd_w", 32'(rd_w), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    drive(NOP, 0, 0, 0, "fill0"); tick();
    drive(NOP, 0, 0, 0, "fill1"); tick();

    // add x5,x1,x2 ; sub x6,x5,x3
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5), 0, 0, 0, "add"); tick();
    drive(enc_r(7'h20, 5'd3, 5'd5, 3'd0, 5'd6), 0, 0, 0, "sub"); tick();
    drive(NOP, 0, 0, 0, "sub_in_e");
    chk("fwd_sub.forward_a_e", 32'(forward_a_e), 32'd2);
    chk("fwd_sub.forward_b_e", 32'(forward_b_e), 32'd0);
    chk("fwd_sub.alu_cntrl_e", 32'(alu_cntrl_e), 32'd1);
    tick();

    // lw x5,0(x1) ; add x6,x5,x2
    drive(enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011), 0, 0, 0, "lw"); tick();
    drive(enc_r(7'h00, 5'd2, 5'd5, 3'd0, 5'd6), 0, 0, 0, "lu_dep");
    chk("loaduse.stall_f", 32'(stall_f), 32'd1);
    chk("loaduse.stall_d", 32'(stall_d), 32'd1);
    chk("loaduse.flush_e", 32'(flush_e), 32'd1);
    tick();
    drive(enc_r(7'h00, 5'd2, 5'd5, 3'd0, 5'd6), 0, 0, 0, "lu_held");
    chk("loaduse_release.stall_f", 32'(stall_f), 32'd0);
    tick();
    drive(NOP, 0, 0, 0, "lu_in_e");
    chk("loaduse_fwd.forward_a_e", 32'(forward_a_e), 32'd1);
    chk("loaduse_fwd.result_src_w", 32'(result_src_w), 32'd1);
    tick();

    // blt x1,x2 taken, sw behind it is squashed
    drive({7'b0, 5'd2, 5'd1, 3'b100, 5'b0, 7'b1100011}, 0, 0, 0, "blt"); tick();
    drive({7'b0, 5'd1, 5'd2, 3'b010, 5'b0, 7'b0100011}, 0, 1, 0, "blt_in_e");
    chk("blt.pc_src_e", 32'(pc_src_e), 32'd1);
    chk("blt.flush_d", 32'(flush_d), 32'd1);
    chk("blt.flush_e", 32'(flush_e), 32'd1);
    chk("blt_beqonly.pc_src_e", 32'(nb_pc_src), 32'd0);
    tick();
    drive(NOP, 0, 0, 0, "blt_bubble");
    chk("blt_bubble.alu_src_e", 32'(alu_src_e), 32'd0);
    tick();
    drive(NOP, 0, 0, 0, "blt_bubble_m");
    chk("blt_bubble.mem_write_m", 32'(mem_write_m), 32'd0);
    tick();

    // addi x0,x0,1 ; add x7,x0,x0
    drive(enc_i(12'd1, 5'd0, 3'd0, 5'd0, 7'b0010011), 0, 0, 0, "addi_x0"); tick();
    drive(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), 0, 0, 0, "add_x0");
    chk("x0.stall_f", 32'(stall_f), 32'd0);
    tick();
    drive(NOP, 0, 0, 0, "x0_in_e");
    chk("x0.forward_a_e", 32'(forward_a_e), 32'd0);
    chk("x0.forward_b_e", 32'(forward_b_e), 32'd0);
    tick();

    // lw x5 ; jal x1 ; dependent add lands behind the taken jump
    drive(enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011), 0, 0, 0, "lw2"); tick();
    drive({20'b0, 5'd1, 7'b1101111}, 0, 0, 0, "jal"); tick();
    drive(enc_r(7'h00, 5'd2, 5'd5, 3'd0, 5'd6), 1, 0, 0, "jal_in_e");
    chk("jal.stall_f", 32'(stall_f), 32'd0);
    chk("jal.flush_d", 32'(flush_d), 32'd1);
    chk("jal.flush_e", 32'(flush_e), 32'd1);
    tick();
    drive(NOP, 0, 0, 0, "jal_after"); tick();

    // unknown opcode drains as a bubble
    drive(32'h0000_02FF, 0, 0, 0, "illegal"); tick();
    drive(NOP, 0, 0, 0, "illegal_e");
    chk("illegal.illegal_e", 32'(illegal_e), 32'd1);
    tick();
    drive(NOP, 0, 0, 0, "illegal_m");
    chk("illegal.mem_write_m", 32'(mem_write_m), 32'd0);
    tick();
    drive(NOP, 0, 0, 0, "illegal_w");
    chk("illegal.reg_write_w", 32'(reg_write_w), 32'd0);
    tick();

    // reset pulled mid-stream with a load-use stall pending
    drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5), 0, 0, 0, "pre_rst0"); tick();
    drive(enc_i(12'd0, 5'd1, 3'd2, 5'd6, 7'b0000011), 0, 0, 0, "pre_rst1"); tick();
    drive(enc_r(7'h00, 5'd5, 5'd6, 3'd0, 5'd8), 0, 0, 0, "pre_rst2");
    #2 rst_n = 1'b0;
    e_s = '0; m_s = '0; w_s = '0;
    #1;
    check_all("midrst");
    chk("midrst.stall_f", 32'(stall_f), 32'd0);
    chk("midrst.reg_write_w", 32'(reg_write_w), 32'd0);
    chk("midrst.forward_a_e", 32'(forward_a_e), 32'd0);
    tick();
    drive(NOP, 0, 0, 0, "in_rst");
    #2 rst_n = 1'b1;
    tick();

    // random instruction streams; the bench acts as fetch (holds on stall, NOP after redirect)
    hold = 1'b0;
    redir = 1'b0;
    cur = NOP;
    for (int i = 0; i < 600; i++) begin
      if (!hold) cur = redir ? NOP : rand_instr();
      drive(cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), "rnd");
      hold  = ref_lw_stall() && !ref_pc(1'b1);
      redir = ref_pc(1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
